// File: rtl/memory_model_rv.sv
// Byte-addressed backing memory with a valid/ready command channel, fixed read latency,
// in-order responses and credit-limited outstanding requests.
module memory_model_rv #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
  parameter int                    MEM_DEPTH    = 4096,
  parameter int                    DATA_WIDTH   = 256,
  parameter int                    READ_LATENCY = 2,
  parameter int                    OUTSTANDING  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wmask_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_err_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int WORDS = MEM_DEPTH / NB;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  localparam logic [CNT_W-1:0]    CREDITS  = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(OUTSTANDING - 1);
  localparam logic [ADDR_WIDTH:0] LO_ADDR  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR  = LO_ADDR + (ADDR_WIDTH + 1)'(MEM_DEPTH);

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] ax;
    ax = {1'b0, a};
    return (ax < LO_ADDR) || (ax >= HI_ADDR) || (a[OFF_W-1:0] != '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_word,
                                                        input logic [NB-1:0]         mask);
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int b = 0; b < NB; b++) begin
      if (mask[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  accept;
  logic                  cmd_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      word_idx;

  logic [READ_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0]   data_p [READ_LATENCY];
  logic                    err_p  [READ_LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [OUTSTANDING];
  logic                  fifo_err  [OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      in_flight;
  logic                  push;
  logic                  pop;

  assign accept   = cmd_valid_i & cmd_ready_o;
  assign cmd_err  = addr_bad(cmd_addr_i);
  assign offset   = cmd_addr_i - BASE_ADDR;
  assign word_idx = IDX_W'(offset >> OFF_W);

  // Storage: written on the acceptance edge, never reset.
  always_ff @(posedge clk_i) begin
    if (accept && cmd_we_i && !cmd_err) begin
      mem[word_idx] <= merge_bytes(mem[word_idx], cmd_wdata_i, cmd_wmask_i);
    end
  end

  // Stage p0 samples the word on the acceptance edge; later stages only delay it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < READ_LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    data_p[0] <= (cmd_we_i || cmd_err) ? '0 : mem[word_idx];
    err_p[0]  <= cmd_err;
    for (int s = 1; s < READ_LATENCY; s++) begin
      data_p[s] <= data_p[s-1];
      err_p[s]  <= err_p[s-1];
    end
  end

  // Response FIFO: credits bound in_flight, so a push never finds it full without a pop.
  assign push = vld_p[READ_LATENCY-1];
  assign pop  = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= data_p[READ_LATENCY-1];
      fifo_err[wr_ptr]  <= err_p[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_flight  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({accept, pop})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Outputs are gated by the FIFO count so reset zeroes them without clearing data storage.
  assign cmd_ready_o = (in_flight < CREDITS);
  assign rsp_valid_o = (fifo_count != '0);
  assign rsp_data_o  = rsp_valid_o ? fifo_data[rd_ptr] : '0;
  assign rsp_err_o   = rsp_valid_o & fifo_err[rd_ptr];

endmodule

// File: tb/tb_memory_model_rv.sv
// Directed bench for memory_model_rv: a byte-level memory model feeds an in-order
// scoreboard that is checked whenever a response handshake is about to occur.
module tb_memory_model_rv;

  localparam int          DW   = 256;
  localparam int          NB   = DW / 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_addr;
  logic          cmd_we;
  logic [NB-1:0] cmd_wmask;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  memory_model_rv dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_we_i    (cmd_we),
    .cmd_wmask_i (cmd_wmask),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mm [128];
  int            checks   = 0;
  int            failures = 0;
  bit            lat_mode  = 1'b0;
  bit            rand_mode = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_err;
  int            last_acc = -1;
  int            bp_edge;

  task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'd4096) || (a[4:0] != 5'd0);
  endfunction

  // One clock: check the pending response and record an acceptance at the negedge,
  // then move to just after the next rising edge where inputs are driven.
  task automatic step();
    exp_t        e;
    bit          accepted;
    logic [31:0] off;
    int          idx;
    accepted = 1'b0;
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk_bit("hold_valid", rsp_valid, 1'b1);
        chk_vec("hold_data", rsp_data, prev_data);
        chk_bit("hold_err", rsp_err, prev_err);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk_bit("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk_vec("rsp_data", rsp_data, e.data);
          chk_bit("rsp_err", rsp_err, e.err);
          if (e.lat) chk_int("rsp_latency", cyc - e.acc, 2);
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_err   = rsp_err;
      if (cmd_valid && cmd_ready) begin
        accepted = 1'b1;
        e.acc    = cyc + 1;
        e.lat    = lat_mode && !cmd_we;
        e.data   = '0;
        e.err    = 1'b0;
        last_acc = cyc + 1;
        if (addr_bad(cmd_addr)) begin
          e.err = 1'b1;
        end else begin
          off = cmd_addr - BASE;
          idx = int'(off >> 5);
          if (cmd_we) begin
            for (int b = 0; b < NB; b++) begin
              if (cmd_wmask[b]) mm[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
            end
          end else begin
            e.data = mm[idx];
          end
        end
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (accepted) cmd_valid = 1'b0;
    if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] a, input logic we, input logic [NB-1:0] m,
                      input logic [DW-1:0] d);
    cmd_addr  = a;
    cmd_we    = we;
    cmd_wmask = m;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && cmd_valid; k++) step();
    if (cmd_valid) begin
      chk_bit("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a);
    send(a, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
    send(a, 1'b1, m, d);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) step();
    chk_int("drain_left", sb.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_we    = 1'b0;
    cmd_wmask = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    #1;
    chk_bit("reset_cmd_ready", cmd_ready, 1'b1);
    chk_bit("reset_rsp_valid", rsp_valid, 1'b0);
    chk_vec("reset_rsp_data", rsp_data, '0);
    chk_bit("reset_rsp_err", rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;

    // Sequential fill and readback with latency measurement
    for (int i = 0; i < 16; i++) wr(BASE + 32'(32 * i), DW'(i + 1), '1);
    drain();
    lat_mode = 1'b1;
    for (int i = 0; i < 16; i++) rd(BASE + 32'(32 * i));
    drain();
    lat_mode = 1'b0;

    // Byte mask
    wr(BASE + 32'h40, '1, '1);
    wr(BASE + 32'h40, '0, 32'h0000_000F);
    rd(BASE + 32'h40);
    drain();

    // Address errors, including a write that must not alias into storage
    rd(32'h3FFF_FFE0);
    rd(32'h4000_1000);
    rd(32'h4000_0004);
    wr(32'h4000_1000, '1, '1);
    drain();

    // Readback under random response stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 16; i++) rd(BASE + 32'(32 * i));
    for (int k = 0; k < 200 && sb.size() != 0; k++) step();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Backpressure: four credits, then the fifth read waits for a response handshake
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) rd(BASE + 32'(32 * i));
    cmd_addr  = BASE + 32'(32 * 4);
    cmd_we    = 1'b0;
    cmd_wmask = '0;
    cmd_wdata = '0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_bit("bp_cmd_ready", cmd_ready, 1'b0);
      chk_bit("bp_still_pending", cmd_valid, 1'b1);
      chk_bit("bp_rsp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    bp_edge   = cyc + 2;
    for (int k = 0; k < 20 && cmd_valid; k++) step();
    cmd_valid = 1'b0;
    chk_int("bp_accept_edge", last_acc, bp_edge);
    rd(BASE + 32'(32 * 5));
    drain();

    // Reset while a write and a read are in flight
    wr(BASE + 32'h80, DW'(8'hAB), '1);
    rd(BASE + 32'h80);
    rst = 1'b1;
    sb.delete();
    #1;
    chk_bit("midrst_cmd_ready", cmd_ready, 1'b1);
    chk_bit("midrst_rsp_valid", rsp_valid, 1'b0);
    chk_vec("midrst_rsp_data", rsp_data, '0);
    chk_bit("midrst_rsp_err", rsp_err, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_bit("postrst_no_rsp", rsp_valid, 1'b0);
    end
    rd(BASE + 32'h80);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_model_rv.md
# memory_model_rv

Parametrised, synthesis-friendly simulation memory with a valid/ready command channel, per-byte write masks, configurable fixed read latency and a bounded number of outstanding requests. It is the next-generation backing store for core and cache testbenches. It replaces the single-cycle, always-ready memory model, adding backpressure, in-order responses and address-error reporting.

## Interface
- BASE_ADDR, 32'h4000_0000: first byte address mapped by the memory.
- MEM_DEPTH, 4096: memory size in bytes; must be a multiple of DATA_WIDTH/8.
- DATA_WIDTH, 256: word width in bits; power of two, at least 32.
- ADDR_WIDTH, 32: byte-address width.
- READ_LATENCY, 2: cycles from command acceptance to response availability; at least 1.
- OUTSTANDING, 4: maximum accepted-but-unconsumed commands; at least 1.
- clk_i  in  1  single clock, all state on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command can be accepted this cycle.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_wmask_i  in  DATA_WIDTH/8  byte-lane write enables.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_data_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  address out of range or misaligned.

## Operation
- A command is accepted on a rising edge where cmd_valid_i & cmd_ready_o.
- Every accepted command, read or write, yields exactly one response. Responses are returned in acceptance order.
- Word index = (cmd_addr_i - BASE_ADDR) >> log2(DATA_WIDTH/8).
- Error conditions:
  - cmd_addr_i < BASE_ADDR.
  - cmd_addr_i >= BASE_ADDR + MEM_DEPTH.
  - Low log2(DATA_WIDTH/8) address bits non-zero.
  - On error: no storage access; the response carries rsp_err_o=1 and rsp_data_o=0.
- Write: on the acceptance edge, byte lane b is updated from cmd_wdata_i when cmd_wmask_i[b]=1; other lanes keep their value. The response has rsp_data_o=0 and rsp_err_o=0.
- Read: the word is sampled on the acceptance edge. A write accepted on an earlier edge is always visible. The response has rsp_data_o equal to the word and rsp_err_o=0.
- Internal structure:
  - A READ_LATENCY-stage delay pipeline (valid, data, err) feeds a response FIFO of OUTSTANDING entries.
  - The pipeline never stalls. Credit accounting guarantees the FIFO never overflows.
- Credit counter in_flight, range 0..OUTSTANDING:
  - +1 on command acceptance, -1 on response handshake; unchanged when both occur in the same cycle.
  - cmd_ready_o = (in_flight < OUTSTANDING), a combinational function of registered in_flight only.
- rsp_valid_o = FIFO not empty. rsp_data_o and rsp_err_o present the FIFO head.
- Response signals must stay stable while rsp_valid_o=1 and rsp_ready_i=0.
- Storage contents are not initialised and not cleared by reset.

## Timing
- Reset values:
  - cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0.
  - in_flight=0; pipeline and FIFO empty.
- Latency: a command accepted at edge T with an empty FIFO gives rsp_valid_o=1 after edge T+READ_LATENCY.
- Throughput: 1 command per cycle while rsp_ready_i=1 and OUTSTANDING >= READ_LATENCY+1. Otherwise throughput is credit-limited to OUTSTANDING per READ_LATENCY+1 cycles.
- Full (in_flight=OUTSTANDING): cmd_ready_o=0. A response handshake at edge T raises cmd_ready_o after T, so a new command is accepted no earlier than T+1.
- FIFO pointers wrap modulo OUTSTANDING. A simultaneous push and pop on a full or empty FIFO is legal and keeps the count.
- cmd_valid_i with cmd_ready_o=0: the command is ignored, has no side effects, and must be held by the source.
- Reset asserted mid-operation: all in-flight commands are discarded with no responses. Writes already accepted remain in storage. Outputs return to reset values immediately (asynchronously).

## Test plan
- Sequential fill (defaults):
  - Stimulus: write i+1, full mask, to BASE_ADDR+32*i for i=0..15, then read back all 16 words.
  - Required: 16 write responses (data 0, err 0), then reads returning 1..16 in order. Each read's rsp_valid_o rises exactly 2 cycles after acceptance.
- Byte mask:
  - Stimulus: write all-ones to 0x4000_0040, then write 0 with mask 32'h0000_000F, then read 0x4000_0040.
  - Required: the read returns all-ones except bytes 0..3, which are 0x00.
- Errors:
  - Stimulus: read 0x3FFF_FFE0, read 0x4000_1000, read 0x4000_0004, and write 0x4000_1000.
  - Required: each response has err=1 and data=0; storage at 0x4000_0000..0x4000_0FFF is unchanged.
- Backpressure:
  - Stimulus: rsp_ready_i=0 with 6 reads issued back-to-back.
  - Required: exactly 4 are accepted and cmd_ready_o=0 afterwards. Raising rsp_ready_i drains 4 in-order responses, and the 2 remaining reads are accepted thereafter.
- Stall stability:
  - Stimulus: toggle rsp_ready_i randomly during the 16-word readback.
  - Required: data is held stable while stalled, with no loss, duplication or reordering.
- Reset mid-flight:
  - Stimulus: assert rst_i 1 cycle after accepting a write to 0x4000_0080 (value 0xAB) and a read.
  - Required: no responses are produced; after reset, a read of 0x4000_0080 returns 0xAB.
